// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority encoder: selection modes,
// FSM state encoding and the one-hot helper used to clear a granted bit.
package prio_enc_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Single-bit encoding so the HOLD state bit is itself the out_valid flop.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Widest legal request vector; callers size-cast the result down to N.
  function automatic logic [255:0] onehot(input int unsigned idx, input int unsigned n);
    logic [255:0] v;
    v = '0;
    if (idx < n) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational search for the first set request at or above a start index,
// wrapping from N-1 back to 0; start = 0 degenerates to lowest-index-wins.
module prio_sel #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  int             hit;

  // Concatenating req with itself turns the wrap-around into a linear search
  // over bits [start, start+N), so one priority scan covers both halves.
  always_comb begin
    dbl = {req, req};
    hit = 0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(start))) hit = j;
    end
    any = |req;
    idx = (hit >= N) ? IW'(hit - N) : IW'(hit);
  end

endmodule

// File: rtl/prio_encoder_q.sv
// Registered N-input priority encoder with sticky pending requests, overflow
// pulse and a valid/ready grant port; fixed-priority or round-robin selection.
module prio_encoder_q
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = PRIO_FIXED,
  localparam int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  in,
  output logic [IW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pend,
  output logic          ovf
);

  state_t        state, state_next;
  logic [IW-1:0] ptr, ptr_next;
  logic [N-1:0]  newreq, clr, pend_next;
  logic          acc, ovf_next, load;
  logic [IW-1:0] sel_idx, sel_start;
  logic          sel_any;

  always_comb begin
    newreq    = en ? in : '0;
    acc       = out_valid && out_ready;
    clr       = acc ? N'(onehot(int'(out), N)) : '0;
    pend_next = (pend & ~clr) | newreq;
    ovf_next  = |(newreq & pend & ~clr);
    ptr_next  = ptr;
    if (acc) ptr_next = (out == IW'(N-1)) ? '0 : out + 1'b1;
    // The round-robin pointer advances before the reload is selected, so the
    // grant just accepted drops to lowest priority in the same cycle.
    sel_start = (MODE == PRIO_RR) ? ptr_next : '0;
  end

  prio_sel #(.N(N)) u_sel (
    .req   (pend_next),
    .start (sel_start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (sel_any) state_next = HOLD;
      HOLD: if (acc && !sel_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    case (state)
      IDLE: load = sel_any;
      HOLD: load = acc && sel_any;
      default: load = 1'b0;
    endcase
  end

  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      pend <= '0;
      ptr  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (load) out <= sel_idx;
      pend <= pend_next;
      ptr  <= ptr_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench: fixed-priority N=8 instance and round-robin N=5 instance.
module tb_prio_encoder_q;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       f_en, f_rdy, f_vld, f_ovf;
  logic [7:0] f_in, f_pend;
  logic [2:0] f_out;

  logic       r_en, r_rdy, r_vld, r_ovf;
  logic [4:0] r_in, r_pend;
  logic [2:0] r_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encoder_q #(.N(8), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .en(f_en), .in(f_in), .out(f_out),
    .out_valid(f_vld), .out_ready(f_rdy), .pend(f_pend), .ovf(f_ovf)
  );

  prio_encoder_q #(.N(5), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(r_en), .in(r_in), .out(r_out),
    .out_valid(r_vld), .out_ready(r_rdy), .pend(r_pend), .ovf(r_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_f(input string tag, input logic v, input logic [2:0] o,
                       input logic [7:0] p, input logic ov);
    chk({tag, ".vld"}, f_vld, v);
    if (v) chk({tag, ".out"}, f_out, o);
    chk({tag, ".pend"}, f_pend, p);
    chk({tag, ".ovf"}, f_ovf, ov);
  endtask

  initial begin
    rst_n = 1'b0;
    f_en = 1'b1; f_in = '0; f_rdy = 1'b0;
    r_en = 1'b1; r_in = '0; r_rdy = 1'b0;
    #12;
    chk_f("rst_fix", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("rst_fix.out", f_out, 0);
    chk("rst_rr.vld", r_vld, 0);
    chk("rst_rr.out", r_out, 0);
    chk("rst_rr.pend", r_pend, 0);
    chk("rst_rr.ovf", r_ovf, 0);
    rst_n = 1'b1;

    // fixed priority burst, consumer always ready
    f_rdy = 1'b1; f_in = 8'b1010_0100;
    step(); chk_f("burst0", 1'b1, 3'd2, 8'b1010_0100, 1'b0);
    f_in = '0;
    step(); chk_f("burst1", 1'b1, 3'd5, 8'b1010_0000, 1'b0);
    step(); chk_f("burst2", 1'b1, 3'd7, 8'b1000_0000, 1'b0);
    step(); chk_f("burst_end", 1'b0, 3'd0, 8'h00, 1'b0);

    // stall: grant held for five cycles
    f_rdy = 1'b0; f_in = 8'b0000_1001;
    step(); chk_f("stall0", 1'b1, 3'd0, 8'b0000_1001, 1'b0);
    f_in = '0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_f("stall_hold", 1'b1, 3'd0, 8'b0000_1001, 1'b0);
    end
    f_rdy = 1'b1;
    step(); chk_f("stall_rel", 1'b1, 3'd3, 8'b0000_1000, 1'b0);
    step(); chk_f("stall_end", 1'b0, 3'd0, 8'h00, 1'b0);

    // duplicate request while pending and stalled
    f_rdy = 1'b0; f_in = 8'b0000_1000;
    step(); chk_f("ovf_first", 1'b1, 3'd3, 8'b0000_1000, 1'b0);
    f_in = '0;
    step(); chk_f("ovf_gap", 1'b1, 3'd3, 8'b0000_1000, 1'b0);
    f_in = 8'b0000_1000;
    step(); chk_f("ovf_dup", 1'b1, 3'd3, 8'b0000_1000, 1'b1);
    f_in = '0;
    step(); chk_f("ovf_drop", 1'b1, 3'd3, 8'b0000_1000, 1'b0);
    f_rdy = 1'b1;
    step(); chk_f("ovf_single_grant", 1'b0, 3'd0, 8'h00, 1'b0);

    // enable low blocks capture
    f_en = 1'b0; f_in = 8'hFF;
    step(); chk_f("en_off0", 1'b0, 3'd0, 8'h00, 1'b0);
    step(); chk_f("en_off1", 1'b0, 3'd0, 8'h00, 1'b0);
    f_en = 1'b1; f_in = '0;

    // re-arrival of the bit being accepted
    f_rdy = 1'b0; f_in = 8'b0000_0010;
    step(); chk_f("rearr0", 1'b1, 3'd1, 8'b0000_0010, 1'b0);
    f_in = '0;
    step(); chk_f("rearr_hold", 1'b1, 3'd1, 8'b0000_0010, 1'b0);
    f_rdy = 1'b1; f_in = 8'b0000_0010;
    step(); chk_f("rearr_again", 1'b1, 3'd1, 8'b0000_0010, 1'b0);
    f_in = '0;
    step(); chk_f("rearr_end", 1'b0, 3'd0, 8'h00, 1'b0);

    // asynchronous reset during HOLD
    f_rdy = 1'b0; f_in = 8'hF0;
    step(); chk_f("mid_hold", 1'b1, 3'd4, 8'hF0, 1'b0);
    f_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_f("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("mid_rst.out", f_out, 0);
    #2 rst_n = 1'b1;
    step(); chk_f("post_rst0", 1'b0, 3'd0, 8'h00, 1'b0);
    step(); chk_f("post_rst1", 1'b0, 3'd0, 8'h00, 1'b0);

    // round-robin, all five lines held high
    r_rdy = 1'b1; r_in = 5'b11111;
    step();
    chk("rr0.vld", r_vld, 1);
    chk("rr0.out", r_out, 0);
    chk("rr0.ovf", r_ovf, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("rr.vld", r_vld, 1);
      chk($sformatf("rr%0d.out", k), r_out, k % 5);
      chk($sformatf("rr%0d.ovf", k), r_ovf, 1);
    end
    r_in = '0;
    step();
    chk("rr_drain.out", r_out, 3);
    chk("rr_drain.ovf", r_ovf, 0);
    chk("rr_drain.pend", r_pend, 5'b11011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
